// File: rtl/sa_psum_collector_pkg.sv
// Shared constants for the systolic-array drain side.
// Holds the default array geometry (columns, partial-sum width, FIFO
// depth) and the clock constants used by benches driving this block.
package sa_psum_collector_pkg;

   localparam int DEFAULT_COLS      = 4;
   localparam int DEFAULT_PSUM_W    = 20;
   localparam int DEFAULT_DEPTH     = 4;

   localparam int HALF_CLOCK_PERIOD = 5;
   localparam int CLOCK_PERIOD      = 2 * HALF_CLOCK_PERIOD;
   localparam int MINIMUM_PERIOD    = CLOCK_PERIOD;

endpackage

// File: rtl/sa_psum_collector_delay_line.sv
// sa_delay_line: fixed-length register pipeline.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high clear, honoured only when USE_RESET=1
//   din    - WIDTH-bit input
//   dout   - din delayed by STAGES cycles (STAGES=0 gives a plain wire)
// Data lanes instantiate this with USE_RESET=0 so they carry no reset
// logic; the valid lane uses USE_RESET=1 so in-flight rows are discarded.
module sa_delay_line
   import sa_psum_collector_pkg::*;
#(
   parameter int WIDTH     = 1,
   parameter int STAGES    = 1,
   parameter bit USE_RESET = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (STAGES == 0) begin : g_wire
      // No registers in this lane; clock and reset are intentionally idle.
      logic unused_ctrl;
      assign unused_ctrl = clk ^ reset;
      assign dout        = din;
   end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [STAGES];

      always_ff @(posedge clk) begin
         if (USE_RESET && reset) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
         end else begin
            stage_q[0] <= din;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign dout = stage_q[STAGES-1];
   end

endmodule

// File: rtl/sa_psum_collector.sv
// sa_psum_collector: drain-side collector of the systolic array.
// Captures the skewed partial sums leaving the bottom of the PE columns,
// re-aligns them into one row per activation vector and queues rows in a
// small FIFO behind a valid/ready handshake.
// Ports:
//   clk, reset     - single clock, synchronous active-high reset
//   psum_in        - column j at bits [j*PSUM_W +: PSUM_W], column j lags
//                    column 0 by j cycles
//   psum_valid_in  - column 0 result valid
//   row_data       - aligned head-of-FIFO row, same packing as psum_in
//   row_valid      - FIFO not empty
//   row_ready      - consumer takes the head row on row_valid & row_ready
//   fifo_full      - FIFO holds DEPTH rows
//   overflow       - sticky: an aligned row was dropped
//   row_count      - rows accepted into the FIFO, wraps at 16 bits
module sa_psum_collector
   import sa_psum_collector_pkg::*;
#(
   parameter int COLS   = DEFAULT_COLS,
   parameter int PSUM_W = DEFAULT_PSUM_W,
   parameter int DEPTH  = DEFAULT_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [COLS*PSUM_W-1:0] psum_in,
   input  logic                   psum_valid_in,
   output logic [COLS*PSUM_W-1:0] row_data,
   output logic                   row_valid,
   input  logic                   row_ready,
   output logic                   fifo_full,
   output logic                   overflow,
   output logic [15:0]            row_count
);

   localparam int ROW_W = COLS * PSUM_W;
   localparam int AW    = $clog2(DEPTH);

   // ---- stage p1: de-skew; column j waits COLS-1-j cycles, valid waits COLS-1
   logic             vld_p1;
   logic [ROW_W-1:0] row_p1;

   sa_delay_line #(
      .WIDTH    (1),
      .STAGES   (COLS - 1),
      .USE_RESET(1'b1)
   ) u_vld_line (
      .clk  (clk),
      .reset(reset),
      .din  (psum_valid_in),
      .dout (vld_p1)
   );

   for (genvar j = 0; j < COLS; j++) begin : g_col
      sa_delay_line #(
         .WIDTH    (PSUM_W),
         .STAGES   (COLS - 1 - j),
         .USE_RESET(1'b0)
      ) u_col_line (
         .clk  (clk),
         .reset(reset),
         .din  (psum_in[j*PSUM_W +: PSUM_W]),
         .dout (row_p1[j*PSUM_W +: PSUM_W])
      );
   end

   // ---- stage p2: row FIFO (pointers carry one extra wrap bit)
   logic [ROW_W-1:0] mem_p2 [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;

   always_comb begin
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      pop   = !empty && row_ready;
      // A pop on the same edge frees the slot, so a full FIFO still accepts.
      push  = vld_p1 && (!full || pop);
      drop  = vld_p1 && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (push) mem_p2[wr_ptr[AW-1:0]] <= row_p1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         row_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr    <= wr_ptr + 1'b1;
            row_count <= row_count + 16'd1;
         end
         if (pop)  rd_ptr   <= rd_ptr + 1'b1;
         if (drop) overflow <= 1'b1;
      end
   end

   assign row_data  = mem_p2[rd_ptr[AW-1:0]];
   assign row_valid = !empty;
   assign fifo_full = full;

endmodule

// File: tb/tb_sa_psum_collector.sv
module tb_sa_psum_collector;
   import sa_psum_collector_pkg::*;

   localparam int COLS   = DEFAULT_COLS;
   localparam int PSUM_W = DEFAULT_PSUM_W;
   localparam int DEPTH  = DEFAULT_DEPTH;
   localparam int ROW_W  = COLS * PSUM_W;
   localparam int MAXC   = 512;

   typedef logic [ROW_W-1:0] row_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   row_t        psum_in = '0;
   logic        psum_valid_in = 1'b0;
   row_t        row_data;
   logic        row_valid;
   logic        row_ready = 1'b0;
   logic        fifo_full;
   logic        overflow;
   logic [15:0] row_count;

   sa_psum_collector #(.COLS(COLS), .PSUM_W(PSUM_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .psum_in      (psum_in),
      .psum_valid_in(psum_valid_in),
      .row_data     (row_data),
      .row_valid    (row_valid),
      .row_ready    (row_ready),
      .fifo_full    (fifo_full),
      .overflow     (overflow),
      .row_count    (row_count)
   );

   always #(HALF_CLOCK_PERIOD) clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Per-cycle stimulus history: which cycles launched a row, its data,
   // and whether reset was driven in that cycle.
   logic launch_v   [MAXC];
   row_t launch_row [MAXC];
   logic rst_hist   [MAXC];
   int   cyc = 0;

   // Reference model: the FIFO contents as a queue plus counters.
   row_t        mq[$];
   int          m_cnt  = 0;
   logic        m_ovf  = 1'b0;
   logic        m_live = 1'b0;

   task automatic chk(input string name, input row_t got, input row_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, exp);
      end
   endtask

   function automatic row_t mk_row(input logic [PSUM_W-1:0] c0, input logic [PSUM_W-1:0] c1,
                                   input logic [PSUM_W-1:0] c2, input logic [PSUM_W-1:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   // Model update: a row launched at edge E lands at edge E+COLS-1 unless
   // reset was seen on any edge in between.
   always @(posedge clk) begin
      int   e;
      logic arr;
      logic was_full;
      logic pop;
      e = cyc;
      if (reset) begin
         mq.delete();
         m_cnt  = 0;
         m_ovf  = 1'b0;
         m_live = 1'b1;
      end else if (m_live) begin
         arr = 1'b0;
         if (e - (COLS - 1) >= 0 && launch_v[e-(COLS-1)]) begin
            arr = 1'b1;
            for (int k = e - (COLS - 1); k <= e; k++) if (rst_hist[k]) arr = 1'b0;
         end
         was_full = (mq.size() == DEPTH);
         pop      = (mq.size() > 0) && row_ready;
         if (pop) void'(mq.pop_front());
         if (arr) begin
            if (!was_full || pop) begin
               mq.push_back(launch_row[e-(COLS-1)]);
               m_cnt = (m_cnt + 1) % 65536;
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
   end

   // Compare process: outputs against the model every cycle once reset has been seen.
   always @(negedge clk) begin
      if (m_live) begin
         chk("row_valid", row_t'(row_valid), row_t'(mq.size() > 0));
         chk("fifo_full", row_t'(fifo_full), row_t'(mq.size() == DEPTH));
         chk("overflow",  row_t'(overflow),  row_t'(m_ovf));
         chk("row_count", row_t'(row_count), row_t'(m_cnt));
         if (mq.size() > 0) chk("row_data", row_data, mq[0]);
      end
   end

   // One clock cycle of stimulus; column j carries the row launched j cycles
   // earlier, or random filler when no row occupies that slot.
   task automatic step(input logic v, input row_t r, input logic rdy, input logic rst);
      row_t tmp;
      launch_v[cyc]   = v;
      launch_row[cyc] = r;
      rst_hist[cyc]   = rst;
      for (int j = 0; j < COLS; j++) begin
         if (cyc - j >= 0 && launch_v[cyc-j])
            tmp[j*PSUM_W +: PSUM_W] = launch_row[cyc-j][j*PSUM_W +: PSUM_W];
         else
            tmp[j*PSUM_W +: PSUM_W] = PSUM_W'($urandom);
      end
      psum_in       = tmp;
      psum_valid_in = v;
      row_ready     = rdy;
      reset         = rst;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
   endtask

   row_t r1, rs, b1, b2, b3, b4, b5, b6, ra, rb, rc, rr;

   initial begin
      for (int i = 0; i < MAXC; i++) begin
         launch_v[i] = 1'b0;
         rst_hist[i] = 1'b0;
         launch_row[i] = '0;
      end
      r1 = mk_row(20'd100, 20'd101, 20'd102, 20'd103);
      rs = mk_row(20'hFFFFF, 20'h80000, 20'h7FFFF, 20'h00000);
      b1 = mk_row(20'h11111, 20'h12222, 20'h13333, 20'h14444);
      b2 = mk_row(20'h21111, 20'h22222, 20'h23333, 20'h24444);
      b3 = mk_row(20'h31111, 20'h32222, 20'h33333, 20'h34444);
      b4 = mk_row(20'h41111, 20'h42222, 20'h43333, 20'h44444);
      b5 = mk_row(20'h51111, 20'h52222, 20'h53333, 20'h54444);
      b6 = mk_row(20'h61111, 20'h62222, 20'h63333, 20'h64444);
      ra = mk_row(20'hA0001, 20'hA0002, 20'hA0003, 20'hA0004);
      rb = mk_row(20'hB0001, 20'hB0002, 20'hB0003, 20'hB0004);
      rc = mk_row(20'hC0001, 20'hC0002, 20'hC0003, 20'hC0004);
      @(negedge clk);

      // Reset held two cycles
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("rst_row_valid", row_t'(row_valid), '0);
      chk("rst_fifo_full", row_t'(fifo_full), '0);
      chk("rst_overflow",  row_t'(overflow),  '0);
      chk("rst_row_count", row_t'(row_count), '0);

      // Single row: three edges of latency, then visible
      step(1'b1, r1, 1'b0, 1'b0);
      idle(2, 1'b0);
      chk("single_not_yet", row_t'(row_valid), '0);
      idle(1, 1'b0);
      chk("single_valid", row_t'(row_valid), row_t'(1));
      chk("single_data",  row_data, {20'd103, 20'd102, 20'd101, 20'd100});
      chk("single_count", row_t'(row_count), row_t'(1));
      idle(1, 1'b1);
      chk("single_popped", row_t'(row_valid), '0);

      // Signed pass-through
      step(1'b1, rs, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("signed_data", row_data, 80'h000007FFFF80000FFFFF);
      idle(1, 1'b1);

      // Back-to-back fill, simultaneous push/pop when full, then overflow
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, b1, 1'b0, 1'b0);
      step(1'b1, b2, 1'b0, 1'b0);
      step(1'b1, b3, 1'b0, 1'b0);
      step(1'b1, b4, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("b2b_full",  row_t'(fifo_full), row_t'(1));
      chk("b2b_count", row_t'(row_count), row_t'(4));
      chk("b2b_head",  row_data, b1);
      step(1'b1, b5, 1'b0, 1'b0);
      idle(2, 1'b0);
      idle(1, 1'b1);
      chk("pushpop_ovf",   row_t'(overflow),  '0);
      chk("pushpop_full",  row_t'(fifo_full), row_t'(1));
      chk("pushpop_count", row_t'(row_count), row_t'(5));
      chk("pushpop_head",  row_data, b2);
      step(1'b1, b6, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("drop_ovf",   row_t'(overflow),  row_t'(1));
      chk("drop_count", row_t'(row_count), row_t'(5));
      chk("drop_head",  row_data, b2);
      idle(5, 1'b1);
      chk("drained", row_t'(row_valid), '0);
      chk("ovf_sticky", row_t'(overflow), row_t'(1));

      // Mid-operation reset with two rows queued and one in flight
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, ra, 1'b0, 1'b0);
      step(1'b1, rb, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("mid_queued", row_t'(row_count), row_t'(2));
      step(1'b1, rc, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("mid_valid", row_t'(row_valid), '0);
      chk("mid_count", row_t'(row_count), '0);
      chk("mid_ovf",   row_t'(overflow),  '0);
      for (int i = 0; i < 5; i++) begin
         idle(1, 1'b0);
         chk("mid_no_late_row", row_t'(row_valid), '0);
      end

      // Mixed traffic with random valid and ready
      for (int i = 0; i < 40; i++) begin
         rr = {PSUM_W'($urandom), PSUM_W'($urandom), PSUM_W'($urandom), PSUM_W'($urandom)};
         step(1'($urandom_range(0, 1)), rr, 1'($urandom_range(0, 1)), 1'b0);
      end
      idle(COLS + DEPTH + 2, 1'b1);
      chk("final_empty", row_t'(row_valid), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
